gcd_req_sequencer: RTL

- Upstream feeder and result collector for the GCD engine.
- Accepts operand pairs on a valid/ready input, buffers them in a small FIFO, and issues them to the engine one at a time with a one-cycle start pulse.
- Waits for the engine's done and returns the result on a valid/ready output.
- Resolves zero-operand requests locally, without using the engine.

---
 rtl/gcd_req_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gcd_req_sequencer.sv
// Request sequencer for the GCD engine: buffers operand pairs, issues them one at a time,
// short-circuits zero operands and returns results. Optional wait timeout under GCD_TIMEOUT_EN.
module gcd_req_sequencer #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] gcd_a,
  output logic [WIDTH-1:0] gcd_b,
  output logic             gcd_start,
  input  logic [WIDTH-1:0] gcd_result,
  input  logic             gcd_done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_error
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t state, next_state;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             push, pop, fifo_empty;
  logic [WIDTH-1:0] head_a, head_b;
  logic             load_engine, load_bypass, capture_done, capture_timeout;
  logic             timeout_hit;

  // A full FIFO refuses pushes even when a pop frees a slot in the same cycle.
  assign in_ready   = (count != CW'(DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count == '0);
  assign head_a     = mem_a[rd_ptr];
  assign head_b     = mem_b[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset_n && push) begin
      mem_a[wr_ptr] <= in_a;
      mem_b[wr_ptr] <= in_b;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state      = state;
    pop             = 1'b0;
    load_engine     = 1'b0;
    load_bypass     = 1'b0;
    capture_done    = 1'b0;
    capture_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          // gcd(0,x) = x and gcd(0,0) = 0, so a zero operand never needs the engine.
          if (head_a == '0 || head_b == '0) begin
            load_bypass = 1'b1;
            next_state  = HOLD;
          end else begin
            load_engine = 1'b1;
            next_state  = ISSUE;
          end
        end
      end
      ISSUE: next_state = WAIT;
      WAIT: begin
        if (gcd_done) begin
          capture_done = 1'b1;
          next_state   = HOLD;
        end else if (timeout_hit) begin
          capture_timeout = 1'b1;
          next_state      = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign gcd_start = (state == ISSUE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gcd_a      <= '0;
      gcd_b      <= '0;
      out_result <= '0;
    end else begin
      if (load_engine) begin
        gcd_a <= head_a;
        gcd_b <= head_b;
      end
      if (load_bypass)          out_result <= head_a | head_b;
      else if (capture_done)    out_result <= gcd_result;
      else if (capture_timeout) out_result <= '0;
    end
  end

`ifdef GCD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt;

  // Counter restarts while issuing so every request gets a full TIMEOUT window in WAIT.
  always_ff @(posedge clk) begin
    if (!reset_n)              wait_cnt <= '0;
    else if (state == ISSUE)   wait_cnt <= '0;
    else if (state == WAIT)    wait_cnt <= wait_cnt + TW'(1);
  end

  assign timeout_hit = (state == WAIT) && (wait_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!reset_n)                        out_error <= 1'b0;
    else if (capture_timeout)            out_error <= 1'b1;
    else if (capture_done || load_bypass) out_error <= 1'b0;
  end
`else
  assign timeout_hit = 1'b0;
  assign out_error   = 1'b0;
`endif

endmodule
